// File: rtl/lut_config_loader.sv
// Streams NBEATS config beats into a shadow register, then commits the whole word
// to config_out with a one-cycle comb_set strobe followed by a one-cycle done pulse.
module lut_config_loader #(
  parameter int INPUTS       = 4,
  parameter int MEM_SIZE     = 2**INPUTS,
  parameter int CONFIG_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CONFIG_WIDTH-1:0] cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [MEM_SIZE-1:0]     config_out,
  output logic                    comb_set,
  output logic                    busy,
  output logic                    done
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | accepting beats into the shadow register
  // COMMIT | config_out holds the new word, comb_set high
  // FINISH | done pulse, then back to IDLE

  localparam int NBEATS = MEM_SIZE / CONFIG_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [MEM_SIZE-1:0] shadow;
  logic [MEM_SIZE-1:0] shadow_next;
  logic               last_beat;
  logic               beat_accept;

  // New beats enter at the MSB end so beat k lands at [k*CONFIG_WIDTH +: CONFIG_WIDTH].
  assign shadow_next = MEM_SIZE'({cfg_data, shadow} >> CONFIG_WIDTH);
  assign last_beat   = (beat_cnt == CNT_W'(NBEATS - 1));
  assign beat_accept = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      shadow     <= '0;
      config_out <= '0;
      cfg_ready  <= 1'b0;
      comb_set   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      comb_set <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            beat_cnt  <= '0;
            shadow    <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          // abort outranks even the final handshake, so no partial commit can slip out
          if (abort) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            shadow    <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
          end else if (beat_accept) begin
            shadow <= shadow_next;
            if (last_beat) begin
              state      <= COMMIT;
              config_out <= shadow_next;
              cfg_ready  <= 1'b0;
              comb_set   <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          state <= FINISH;
          done  <= 1'b1;
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed and randomized checks of lut_config_loader against a transaction-level
// model that tracks accepted beats and the committed word.
module tb_lut_config_loader;

  localparam int INPUTS = 4;
  localparam int CW     = 4;
  localparam int MS     = 16;
  localparam int NB     = MS / CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [CW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [MS-1:0] config_out;
  logic          comb_set;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // model: loading flag, accepted beats, committed word, cycles left after commit
  bit            m_loading = 1'b0;
  logic [CW-1:0] m_beats[$];
  logic [MS-1:0] m_cfg = '0;
  int            m_tail = 0;

  lut_config_loader #(.INPUTS(INPUTS), .MEM_SIZE(MS), .CONFIG_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .config_out(config_out),
    .comb_set  (comb_set),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MS-1:0] pack_beats();
    logic [MS-1:0] w = '0;
    for (int k = 0; k < NB; k++) w = w | (MS'(m_beats[k]) << (k * CW));
    return w;
  endfunction

  // advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    if (rst) begin
      m_loading = 1'b0;
      m_beats.delete();
      m_cfg  = '0;
      m_tail = 0;
    end else if (m_tail > 0) begin
      m_tail--;
    end else if (!m_loading) begin
      if (start) begin
        m_loading = 1'b1;
        m_beats.delete();
      end
    end else if (abort) begin
      m_loading = 1'b0;
      m_beats.delete();
    end else if (cfg_valid) begin
      m_beats.push_back(cfg_data);
      if (m_beats.size() == NB) begin
        m_cfg     = pack_beats();
        m_loading = 1'b0;
        m_tail    = 2;
      end
    end
  endtask

  task automatic compare_all();
    check("config_out", 32'(config_out), 32'(m_cfg));
    check("comb_set",   32'(comb_set),   32'(m_tail == 2));
    check("done",       32'(done),       32'(m_tail == 1));
    check("busy",       32'(busy),       32'(m_loading || m_tail > 0));
    check("cfg_ready",  32'(cfg_ready),  32'(m_loading));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_beat(input logic [CW-1:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic begin_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    tick();
    tick();
    check("reset_cfg", 32'(config_out), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick();

    // basic back-to-back load
    begin_load();
    send_beat(4'h1); send_beat(4'h2); send_beat(4'h3); send_beat(4'h4);
    check("basic_cfg", 32'(config_out), 32'h4321);
    check("basic_comb_set", 32'(comb_set), 32'h1);
    tick();
    check("basic_done", 32'(done), 32'h1);
    tick();
    check("basic_idle_busy", 32'(busy), 32'h0);

    // stalled stream
    begin_load();
    for (int b = 1; b <= 4; b++) begin
      send_beat(CW'(b));
      if (b < 4) begin
        for (int s = 0; s < 3; s++) begin
          tick();
          check("stall_ready", 32'(cfg_ready), 32'h1);
        end
      end
    end
    check("stall_cfg", 32'(config_out), 32'h4321);
    check("stall_comb_set", 32'(comb_set), 32'h1);
    tick(); tick();

    // abort mid-load keeps the previous word
    begin_load();
    send_beat(4'h3); send_beat(4'hC); send_beat(4'h5); send_beat(4'hA);
    tick(); tick();
    check("abort_pre_cfg", 32'(config_out), 32'hA5C3);
    begin_load();
    send_beat(4'h7); send_beat(4'h8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_cfg", 32'(config_out), 32'hA5C3);
    tick();
    check("abort_no_comb", 32'(comb_set), 32'h0);

    // abort coincident with the final beat
    begin_load();
    send_beat(4'h1); send_beat(4'h1); send_beat(4'h1);
    abort = 1'b1;
    send_beat(4'h1);
    abort = 1'b0;
    check("abort_last_comb", 32'(comb_set), 32'h0);
    tick();
    check("abort_last_done", 32'(done), 32'h0);
    check("abort_last_cfg", 32'(config_out), 32'hA5C3);

    // reset mid-load, then a clean load
    begin_load();
    send_beat(4'h9); send_beat(4'h6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_cfg", 32'(config_out), 32'h0);
    check("rst_ready", 32'(cfg_ready), 32'h0);
    begin_load();
    send_beat(4'hF); send_beat(4'hE); send_beat(4'hD); send_beat(4'hC);
    check("rst_reload_cfg", 32'(config_out), 32'hCDEF);
    tick(); tick();

    // start held high: exactly one load per IDLE entry
    start = 1'b1;
    tick();
    send_beat(4'h2); send_beat(4'h4); send_beat(4'h6); send_beat(4'h8);
    check("hold_cfg", 32'(config_out), 32'h8642);
    tick();
    check("hold_done", 32'(done), 32'h1);
    tick();
    check("hold_idle", 32'(busy), 32'h0);
    tick();
    check("hold_reload", 32'(cfg_ready), 32'h1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 29) == 0);
      cfg_valid = ($urandom_range(0, 2) != 0);
      cfg_data  = CW'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_config_loader.md
LUT_CONFIG_LOADER -- requirements
Module: lut_config_loader

Interface
REQ-001 The block SHALL have parameter INPUTS, default 4, giving the LUT address width.
REQ-002 The block SHALL have parameter MEM_SIZE, default 2**INPUTS, giving the LUT config bits.
REQ-003 The block SHALL have parameter CONFIG_WIDTH, default 4, giving the bits per stream beat; MEM_SIZE SHALL be a multiple of CONFIG_WIDTH, and NBEATS = MEM_SIZE/CONFIG_WIDTH.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a new load; sampled only in IDLE.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel an in-progress load.
REQ-008 The block SHALL have port cfg_data, input, CONFIG_WIDTH bits: config stream beat.
REQ-009 The block SHALL have port cfg_valid, input, 1 bit: cfg_data is valid.
REQ-010 The block SHALL have port cfg_ready, output, 1 bit: the loader accepts a beat.
REQ-011 The block SHALL have port config_out, output, MEM_SIZE bits: drives the LUT config_in.
REQ-012 The block SHALL have port comb_set, output, 1 bit: drives the LUT comb_set.
REQ-013 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD, COMMIT and FINISH.
REQ-016 In IDLE, start=1 SHALL move the FSM to LOAD on the next cycle and clear the beat counter; start SHALL be ignored in every other state.
REQ-017 cfg_ready SHALL be 1 only in LOAD; a beat SHALL be accepted only on a cycle where cfg_valid=1 and cfg_ready=1.
REQ-018 Accepted beat k (0-based) SHALL end up in shadow bits [k*CONFIG_WIDTH +: CONFIG_WIDTH], implemented as a right shift with new data entering at the MSB end.
REQ-019 The beat counter SHALL count 0 to NBEATS-1; acceptance of beat NBEATS-1 SHALL move the FSM to COMMIT.
REQ-020 cfg_valid low in LOAD SHALL stall the load indefinitely with no timeout.
REQ-021 On entry to COMMIT, config_out SHALL load the full shadow word; config_out SHALL change only on this transition and on reset.
REQ-022 comb_set SHALL be 1 for exactly the single COMMIT cycle, with config_out already stable in that cycle; COMMIT SHALL then go to FINISH.
REQ-023 done SHALL be 1 for exactly the single FINISH cycle; FINISH SHALL then go to IDLE.
REQ-024 Latency: comb_set SHALL rise 1 cycle after the last-beat handshake, and done SHALL rise 2 cycles after it.
REQ-025 abort=1 in LOAD SHALL return the FSM to IDLE next cycle, discard the partial shadow, and leave config_out unchanged with no comb_set.
REQ-026 If abort=1 and the final-beat handshake occur in the same cycle, abort SHALL win: no COMMIT, and config_out is unchanged.
REQ-027 abort SHALL have no effect in IDLE, COMMIT or FINISH.
REQ-028 Outputs SHALL be registered or decoded from state only, with no combinational path from cfg_valid to cfg_ready.

Reset
REQ-029 While rst=1, on each clock edge the state SHALL become IDLE and the counter and shadow SHALL be cleared.
REQ-030 While rst=1, the outputs SHALL be config_out=0, comb_set=0, cfg_ready=0, busy=0 and done=0.
REQ-031 rst asserted mid-LOAD or mid-COMMIT SHALL win over all other inputs, and no partial commit SHALL occur.

Verification (INPUTS=4, CONFIG_WIDTH=4, NBEATS=4)
REQ-032 Basic load: start, then beats 0x1,0x2,0x3,0x4 back-to-back -> config_out=16'h4321; comb_set=1 for one cycle one cycle after beat 3; done one cycle later; busy=0 after done.
REQ-033 Stalled stream: the same beats with cfg_valid low 3 cycles between each beat -> identical result with latency stretched; cfg_ready stays 1 throughout LOAD.
REQ-034 Abort: load 16'hA5C3, then start, 2 beats, then abort -> config_out stays 16'hA5C3, comb_set never asserts, FSM returns to IDLE next cycle.
REQ-035 Abort vs final beat: abort coincident with beat 3 handshake -> no comb_set, no done, config_out unchanged.
REQ-036 Reset mid-load: rst pulsed after 2 beats -> all outputs 0 next cycle; a following full load of 0xF,0xE,0xD,0xC yields 16'hCDEF.
REQ-037 Ignored start: start held high through LOAD/COMMIT/FINISH -> exactly one load per IDLE entry, with a new load beginning the cycle after IDLE is re-entered.
